// File: rtl/cpu_final_project_pio_pkg.sv
// PIO input capture: register map, edge modes and warm-up count.
// Shared by the capture top, its interface users and the testbench.
package cpu_final_project_pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MODE = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_DBTH = 3'd4;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_ANY  = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  localparam logic [1:0] WARMUP = 2'd3;

endpackage

// File: rtl/cpu_final_project_pio_in_capture_if.sv
// Avalon-MM slave port s1 of the PIO input capture block.
// master drives address/strobe/data, slave returns readdata.
interface cpu_final_project_pio_in_capture_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/cpu_final_project_pio_debounce.sv
// One-bit debouncer: output adopts the input only after it has
// disagreed with the output for more than th consecutive cycles.
module cpu_final_project_pio_debounce #(
  parameter int DB_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [DB_W-1:0] th,
  input  logic            din,
  output logic            dout
);

  logic [DB_W-1:0] cnt;

  // Count disagreement cycles; flip the output once the count hits th
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt >= th) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_final_project_pio_in_capture.sv
// PIO input port with sync, edge capture, masked irq.
// Optional per-bit debounce under macro CPU_PIO_DEBOUNCE_EN.
module cpu_final_project_pio_in_capture
  import cpu_final_project_pio_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int DB_W     = 16,
  parameter int DB_RESET = 5000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cpu_final_project_pio_in_capture_if.slave bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [1:0]       wu_cnt;
  mode_e            mode_q;
  logic             wr;
  logic             sel_data;
  logic             sel_mode;
  logic             sel_mask;
  logic             sel_edge;
  logic             sel_dbth;
  logic [31:0]      dbth_rd;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign sel_data = bus.address == ADDR_DATA;
  assign sel_mode = bus.address == ADDR_MODE;
  assign sel_mask = bus.address == ADDR_MASK;
  assign sel_edge = bus.address == ADDR_EDGE;
  assign sel_dbth = bus.address == ADDR_DBTH;

  // Upper writedata bits are don't-care for narrow registers
  assign unused_wd = ^bus.writedata;

  // Two-flop synchroniser for the asynchronous board inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef CPU_PIO_DEBOUNCE_EN
  logic [DB_W-1:0] dbth_q;

  // Debounce threshold register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbth_q <= DB_W'(DB_RESET);
    end else if (wr && sel_dbth) begin
      dbth_q <= bus.writedata[DB_W-1:0];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    cpu_final_project_pio_debounce #(
      .DB_W(DB_W)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .th     (dbth_q),
      .din    (sync2[i]),
      .dout   (value[i])
    );
  end

  assign dbth_rd = 32'(dbth_q);
`else
  logic [DB_W-1:0] unused_db;

  assign unused_db = DB_W'(DB_RESET);
  assign value     = sync2;
  assign dbth_rd   = '0;
`endif

  assign rise = value & ~prev;
  assign fall = ~value & prev;

  // Warm-up counter holds capture off until prev is meaningful
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wu_cnt <= '0;
      prev   <= '0;
    end else begin
      prev <= value;
      if (wu_cnt != WARMUP) begin
        wu_cnt <= wu_cnt + 2'd1;
      end
    end
  end

  // Select which detected edges are captured this cycle
  always_comb begin
    hit = '0;
    if (wu_cnt == WARMUP) begin
      unique case (mode_q)
        MODE_RISE: hit = rise;
        MODE_FALL: hit = fall;
        MODE_ANY:  hit = rise | fall;
        MODE_OFF:  hit = '0;
      endcase
    end
  end

  assign clr = (wr && sel_edge) ? bus.writedata[WIDTH-1:0] : '0;

  // MODE and MASK control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_RISE;
      mask_q <= '0;
    end else if (wr) begin
      if (sel_mode) begin
        mode_q <= mode_e'(bus.writedata[1:0]);
      end
      if (sel_mask) begin
        mask_q <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  // Edge capture: a new edge wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~clr) | hit;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_q & mask_q);
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_data: rd_mux = 32'(value);
      sel_mode: rd_mux = {30'd0, mode_q};
      sel_mask: rd_mux = 32'(mask_q);
      sel_edge: rd_mux = 32'(edge_q);
      sel_dbth: rd_mux = dbth_rd;
      default:  rd_mux = '0;
    endcase
  end

  // One-cycle registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux;
    end
  end

endmodule
